digit_serial_addsub32: RTL
==========================

Name: digit_serial_addsub32

Overview:
- Multi-cycle, digit-serial 32-bit adder/subtractor with a start/ready/done handshake.
- Responder counterpart to the adder stimulus benches: accepts one operand pair, processes DIGIT_W bits per clock, and returns sum, cout and OF as a registered result.
- Sits beside the combinational carry-select/skip/lookahead adders as the area-lean sequential option.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of DIGIT_W.
- DIGIT_W, 8, bits added per clock; N = WIDTH/DIGIT_W digit cycles; DIGIT_W = WIDTH gives a single digit cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready = 1.
- a  input  WIDTH  operand A; latched on acceptance.
- b  input  WIDTH  operand B; latched on acceptance.
- cin  input  1  carry-in for add; ignored when sub = 1.
- sub  input  1  0: a+b+cin; 1: a+~b+1 (two's-complement a-b).
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held stable until the next acceptance.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- OF  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; ready=1; done=0; sum=0; cout=0; OF=0; digit counter=0.
- States:
  - IDLE: ready=1. start=1 at an edge: latch a, (sub ? ~b : b), carry = (sub ? 1 : cin), counter=0; go to RUN.
  - RUN: ready=0. Each edge adds digit[counter] of the latched operands plus the carry register and writes that digit of the sum. After digit N-1: compute cout and OF, pulse done, go to DONE.
  - DONE: done=1 for exactly this cycle, ready=0. Next edge: go to IDLE, done=0.
- Latency:
  - Acceptance edge T0; digits are written at edges T1..TN.
  - done is high for the cycle following edge TN.
  - ready returns high after edge TN+1.
  - Throughput is one operation per N+2 cycles.
- start while ready=0 is ignored and not queued. Operand changes after acceptance have no effect.
- sum, cout and OF are updated only at digit write edges. Intermediate sum digits may be visible during RUN; consumers must qualify with done.
- Width rules:
  - Internal digit add is DIGIT_W+1 bits; the carry register is 1 bit.
  - OF uses the carry into bit WIDTH-1, taken from the last digit.
- rst=1 in any state, including mid-RUN: next state IDLE, all outputs return to reset values, and the in-flight result is discarded.
- rst and start asserted at the same edge: rst wins; start is not accepted.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when OF=1 at completion, sum clamps to 0x7FFFFFFF if the latched A MSB = 0, else 0x80000000. cout and OF are still reported unchanged.
- Undefined: sum is always the wrapped modulo-2^WIDTH result.

Test Plan:
- Add, positive overflow: a=0x5FFFE8CA, b=0x54F4FFFF, cin=0, sub=0 -> done exactly 4 edges after acceptance; sum=0xB4F4E8C9, cout=0, OF=1. With ADDSUB_SATURATE_EN: sum=0x7FFFFFFF.
- Add, negative overflow with carry: a=0xA0A0FFFF, b=0xA0BFFFE0 -> sum=0x4160FFDF, cout=1, OF=1. With ADDSUB_SATURATE_EN: sum=0x80000000.
- Add with cin=1: a=0xDFFFE8CA, b=0xCFFFF8CA -> sum=0xAFFFE195, cout=1, OF=0. Repeat with DIGIT_W=32: same result, done 1 edge after acceptance.
- Subtract:
  - a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, OF=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, OF=1.
- Handshake:
  - start held high continuously -> one acceptance per 6 cycles (N=4); ready low from T0+1 through the DONE cycle.
  - Operands changed during RUN -> no effect on the result.
  - Outputs held while idle.
- Reset mid-operation: rst=1 at edge T2 of a run -> next cycle ready=1, done=0, sum=0, cout=0, OF=0; a subsequent start completes normally.

Source files
------------

// File: rtl/digit_serial_addsub32_if.sv
// Operand/result bundle for digit_serial_addsub32: start/ready/done handshake plus
// operands and registered result. The requester uses the master modport.
interface digit_serial_addsub32_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             OF;

  modport master (
    output start, a, b, cin, sub,
    input  ready, done, sum, cout, OF
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, done, sum, cout, OF
  );
endinterface

// File: rtl/digit_serial_addsub32.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT_W bits per clock, IDLE/RUN/DONE handshake.
// Optional macro ADDSUB_SATURATE_EN clamps the sum to the signed limit on overflow.
module digit_serial_addsub32 #(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_addsub32_if.slave bus
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               of_r;
  logic               ready_r;
  logic               done_r;

  int                 idx_s;
  logic [DIGIT_W-1:0] a_dig_s;
  logic [DIGIT_W-1:0] b_dig_s;
  logic [DIGIT_W:0]   dsum_s;
  logic               msb_cin_s;
  logic               of_s;
  logic               last_s;
  logic [WIDTH-1:0]   wrap_sum_s;
  logic [WIDTH-1:0]   sum_next_s;

  // Digit adder: current digit of the latched operands plus the running carry.
  always_comb begin
    idx_s      = int'(cnt_r) * DIGIT_W;
    a_dig_s    = a_r[idx_s +: DIGIT_W];
    b_dig_s    = b_r[idx_s +: DIGIT_W];
    dsum_s     = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT_W{1'b0}}, carry_r};
    // Carry into the digit MSB recovered from the sum bit; meaningful on the last digit only.
    msb_cin_s  = a_dig_s[DIGIT_W-1] ^ b_dig_s[DIGIT_W-1] ^ dsum_s[DIGIT_W-1];
    of_s       = msb_cin_s ^ dsum_s[DIGIT_W];
    last_s     = (cnt_r == LAST_DIGIT);
    wrap_sum_s = sum_r;
    wrap_sum_s[idx_s +: DIGIT_W] = dsum_s[DIGIT_W-1:0];
  end

`ifdef ADDSUB_SATURATE_EN
  // Clamp toward the sign of A when the final digit overflows.
  always_comb begin
    sum_next_s = wrap_sum_s;
    if (last_s && of_s) begin
      sum_next_s = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_next_s = wrap_sum_s;
    end
  end
`else
  // Wrapped modulo-2^WIDTH result.
  always_comb begin
    sum_next_s = wrap_sum_s;
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, digit datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      of_r    <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_next_s == IDLE);
      done_r  <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= dsum_s[DIGIT_W];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            cout_r <= dsum_s[DIGIT_W];
            of_r   <= of_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.cout  = cout_r;
  assign bus.OF    = of_r;
endmodule
